rr_mux_arbiter: RTL and testbench
=================================

RR_MUX_ARBITER -- requirements
Module: rr_mux_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing the N-to-1 select datapath; legal range 2..16.
REQ-002 Parameter WIDTH, default 8: width of each requester's data word.
REQ-003 Parameter MAX_HOLD, default 16: maximum contiguous grant cycles when the timeout feature is compiled in; legal range 2..255.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req  input  N  per-requester request level; bit i belongs to requester i.
REQ-007 in  input  N*WIDTH  concatenated requester data; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 grant  output  N  one-hot grant, registered; all zero when idle.
REQ-010 sel  output  $clog2(N)  binary index of granted requester, registered; drives the shared mux select.
REQ-011 out_valid  output  1  registered; high exactly when the state is GRANT.
REQ-012 out_data  output  WIDTH  in[sel*WIDTH +: WIDTH] when out_valid, else zero; combinational from registered sel.
REQ-013 xfer  output  N  one-hot pulse, combinational: grant & {N{out_valid & out_ready}}, marking the accepted beat's owner.

Function
REQ-014 States: IDLE and GRANT; no other encodings reachable.
REQ-015 IDLE: req all zero -> stay IDLE; outputs grant=0, out_valid=0, sel holds its last value.
REQ-016 IDLE with any req bit set -> GRANT next edge; winner is the first set bit searching upward from last+1, wrapping modulo N.
REQ-017 On entry to GRANT: grant[winner]=1, sel=winner, last=winner, hold counter=0.
REQ-018 GRANT with req[sel]=1 -> stay GRANT; grant and sel unchanged; hold counter increments each cycle, saturating at MAX_HOLD-1.
REQ-019 GRANT with req[sel]=0 -> IDLE next edge, regardless of out_ready; the beat in that cycle is still valid and transfers if out_ready=1.
REQ-020 Arbitration latency: 1 cycle from req to grant when IDLE; 1 idle turnaround cycle between consecutive grants.
REQ-021 Requests from non-granted requesters are ignored while in GRANT; no queuing, levels only.
REQ-022 out_valid does not depend on out_ready; a stalled beat (out_ready=0) holds the same sel and data.
REQ-023 Simultaneous requests in IDLE: only the round-robin winner is granted; a requester granted at index k has lowest priority in the next arbitration.
REQ-024 sel out of range (N not a power of two) is unreachable; out_data is zero for any unreachable index.

Reset
REQ-025 While rst=1 at a rising edge: state=IDLE, grant=0, sel=0, out_valid=0, hold counter=0, last=N-1 so requester 0 wins first after reset.
REQ-026 Reset asserted mid-GRANT aborts the grant on that edge; no xfer pulse occurs in the following cycle.

Configuration
REQ-027 Macro RR_MUX_ARBITER_TIMEOUT_EN defined: in GRANT, when the hold counter equals MAX_HOLD-1 and any other req bit is set, the state goes to IDLE on the next edge even if req[sel]=1 (forced release); round-robin then proceeds from last.
REQ-028 Forced release with no other requester pending does not occur; grant continues with counter saturated.
REQ-029 Macro not defined: no hold counter logic; grant is released only by req[sel] deasserting.

Verification
REQ-030 Reset then req=4'b0101 held one cycle before release -> grant=4'b0001, sel=0 one cycle after req; after req[0] drops, IDLE, then grant=4'b0100, sel=2.
REQ-031 N=4, WIDTH=8, in=32'hA9_94_4A_59, req=4'b1000, out_ready=1 -> out_valid=1, sel=3, out_data=8'hA9, xfer=4'b1000 every GRANT cycle.
REQ-032 All four requesting and each releasing after 2 cycles -> grant order 0,1,2,3,0 with one IDLE cycle between each.
REQ-033 Granted requester 1, out_ready=0 for 3 cycles -> out_valid=1, sel=1, out_data constant, xfer=0; out_ready=1 -> xfer=4'b0010.
REQ-034 With RR_MUX_ARBITER_TIMEOUT_EN, MAX_HOLD=4, req=4'b0011 held -> grant 0 for 4 cycles, IDLE 1 cycle, grant 1 for 4 cycles, repeating; without the macro grant stays at 0.
REQ-035 rst asserted for one cycle during GRANT of requester 2 -> next cycle grant=0, out_valid=0; with req=4'b0100 still set, grant=4'b0100 one cycle after rst deasserts.

Source files
------------

// File: rtl/rr_mux_arbiter.sv
// Round-robin N-to-1 arbiter driving a shared data mux; grant/sel/out_valid registered, out_data and xfer combinational.
// Optional forced release after MAX_HOLD cycles is compiled in with `define RR_MUX_ARBITER_TIMEOUT_EN.
module rr_mux_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*WIDTH-1:0]     in,
    input  logic                   out_ready,
    output logic [N-1:0]           grant,
    output logic [$clog2(N)-1:0]   sel,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [N-1:0]           xfer
);
    localparam int SELW = $clog2(N);

    generate
        if (N < 2 || N > 16 || MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_param
            $error("rr_mux_arbiter: parameter out of legal range");
        end
    endgenerate

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state;
    logic [SELW-1:0] last;
    logic [SELW-1:0] winner;
    logic [SELW-1:0] idx;
    logic [N-1:0]    win_onehot;
    logic            found;
    logic            force_release;

    // First requester above the previous winner, wrapping, so the last winner ranks lowest.
    always_comb begin
        found  = 1'b0;
        winner = last;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = SELW'((int'(last) + k) % N);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    always_comb begin
        win_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (winner == SELW'(i)) win_onehot[i] = 1'b1;
        end
    end

`ifdef RR_MUX_ARBITER_TIMEOUT_EN
    logic [7:0] hold_cnt;
    assign force_release = (hold_cnt == 8'(MAX_HOLD - 1)) && |(req & ~grant);
`else
    assign force_release = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant     <= '0;
            sel       <= '0;
            out_valid <= 1'b0;
            last      <= SELW'(N - 1);
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        state     <= GRANT;
                        grant     <= win_onehot;
                        sel       <= winner;
                        last      <= winner;
                        out_valid <= 1'b1;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
                        hold_cnt  <= '0;
`endif
                    end
                end
                GRANT: begin
                    // Release is independent of out_ready; the current beat still shows this cycle.
                    if (!req[sel] || force_release) begin
                        state     <= IDLE;
                        grant     <= '0;
                        out_valid <= 1'b0;
                    end
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
                    else if (hold_cnt != 8'(MAX_HOLD - 1)) begin
                        hold_cnt <= hold_cnt + 8'd1;
                    end
`endif
                end
                default: begin
                    state     <= IDLE;
                    grant     <= '0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    // Unreachable select values fall through to zero.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < N; i++) begin
            if (out_valid && sel == SELW'(i)) out_data = in[i*WIDTH +: WIDTH];
        end
    end

    assign xfer = grant & {N{out_valid & out_ready}};

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Bench for rr_mux_arbiter (N=4, WIDTH=8, MAX_HOLD=4); expected beats queued at drive time, popped after each edge.
module tb_rr_mux_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] in;
    logic        out_ready;
    logic [3:0]  grant;
    logic [1:0]  sel;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [3:0]  xfer;

    rr_mux_arbiter #(.N(4), .WIDTH(8), .MAX_HOLD(4)) dut (
        .clk(clk), .rst(rst), .req(req), .in(in), .out_ready(out_ready),
        .grant(grant), .sel(sel), .out_valid(out_valid), .out_data(out_data), .xfer(xfer)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] g;
        logic [1:0] s;
        logic       v;
        logic [7:0] d;
        logic [3:0] x;
    } obs_t;

    obs_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cur_sel  = 0;
    logic [31:0] data_words = 32'hA9_94_4A_59;

    function automatic obs_t expect_beat(int owner, int idle_sel, logic rdy);
        obs_t e;
        if (owner < 0) begin
            e = '{g: 4'b0, s: 2'(idle_sel), v: 1'b0, d: 8'h00, x: 4'b0};
        end else begin
            e.g = 4'b1 << owner;
            e.s = 2'(owner);
            e.v = 1'b1;
            e.d = data_words[owner*8 +: 8];
            e.x = rdy ? (4'b1 << owner) : 4'b0;
        end
        return e;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o = '{g: grant, s: sel, v: out_valid, d: out_data, x: xfer};
        return o;
    endfunction

    task automatic test_reset();
        obs_t e, o;
        rst = 1'b1; req = 4'b0; out_ready = 1'b1; in = data_words;
        for (int c = 0; c < 2; c++) begin
            sb.push_back(expect_beat(-1, 0, 1'b1));
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset c%0d: got g=%b s=%0d v=%b d=%h x=%b want g=%b s=%0d v=%b d=%h x=%b",
                         c, o.g, o.s, o.v, o.d, o.x, e.g, e.s, e.v, e.d, e.x);
            end
        end
        rst = 1'b0;
        cur_sel = 0;
    endtask

    task automatic test_basic_rr();
        logic [3:0] rq [5] = '{4'b0101, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
        int         ow [5] = '{0, -1, 2, -1, -1};
        obs_t e, o;
        for (int c = 0; c < 5; c++) begin
            req = rq[c];
            if (ow[c] >= 0) cur_sel = ow[c];
            sb.push_back(expect_beat(ow[c], cur_sel, out_ready));
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL basic_rr c%0d: got g=%b s=%0d v=%b d=%h x=%b want g=%b s=%0d v=%b d=%h x=%b",
                         c, o.g, o.s, o.v, o.d, o.x, e.g, e.s, e.v, e.d, e.x);
            end
        end
    endtask

    task automatic test_top_requester();
        logic [3:0] rq [4] = '{4'b1000, 4'b1000, 4'b1000, 4'b0000};
        int         ow [4] = '{3, 3, 3, -1};
        obs_t e, o;
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            req = rq[c];
            if (ow[c] >= 0) cur_sel = ow[c];
            sb.push_back(expect_beat(ow[c], cur_sel, out_ready));
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL top_req c%0d: got g=%b s=%0d v=%b d=%h x=%b want g=%b s=%0d v=%b d=%h x=%b",
                         c, o.g, o.s, o.v, o.d, o.x, e.g, e.s, e.v, e.d, e.x);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] rq [14] = '{4'hF, 4'hF, 4'hE, 4'hF, 4'hF, 4'hD, 4'hF,
                                4'hF, 4'hB, 4'hF, 4'hF, 4'h7, 4'hF, 4'h0};
        int         ow [14] = '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0, -1};
        obs_t e, o;
        out_ready = 1'b1;
        for (int c = 0; c < 14; c++) begin
            req = rq[c];
            if (ow[c] >= 0) cur_sel = ow[c];
            sb.push_back(expect_beat(ow[c], cur_sel, out_ready));
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL back_to_back c%0d: got g=%b s=%0d v=%b d=%h x=%b want g=%b s=%0d v=%b d=%h x=%b",
                         c, o.g, o.s, o.v, o.d, o.x, e.g, e.s, e.v, e.d, e.x);
            end
        end
    endtask

    task automatic test_stall();
        logic [3:0] rq [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000};
        logic       rd [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int         ow [6] = '{1, 1, 1, 1, -1, -1};
        obs_t e, o;
        for (int c = 0; c < 6; c++) begin
            req = rq[c]; out_ready = rd[c];
            if (ow[c] >= 0) cur_sel = ow[c];
            sb.push_back(expect_beat(ow[c], cur_sel, out_ready));
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL stall c%0d: got g=%b s=%0d v=%b d=%h x=%b want g=%b s=%0d v=%b d=%h x=%b",
                         c, o.g, o.s, o.v, o.d, o.x, e.g, e.s, e.v, e.d, e.x);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        logic [3:0] rq [5] = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
        logic       rs [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        int         ow [5] = '{2, 2, -1, 2, -1};
        obs_t e, o;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            req = rq[c]; rst = rs[c];
            if (rs[c]) cur_sel = 0;
            else if (ow[c] >= 0) cur_sel = ow[c];
            sb.push_back(expect_beat(ow[c], cur_sel, out_ready));
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL reset_mid_grant c%0d: got g=%b s=%0d v=%b d=%h x=%b want g=%b s=%0d v=%b d=%h x=%b",
                         c, o.g, o.s, o.v, o.d, o.x, e.g, e.s, e.v, e.d, e.x);
            end
        end
        rst = 1'b0;
    endtask

    // Two requesters held: forced alternation with the timeout, otherwise requester 0 keeps the grant.
    task automatic test_timeout();
        obs_t e, o;
        int   owner;
        out_ready = 1'b1;
        for (int c = 0; c < 21; c++) begin
            req = (c < 20) ? 4'b0011 : 4'b0000;
`ifdef RR_MUX_ARBITER_TIMEOUT_EN
            owner = ((c % 5) == 4 || c == 20) ? -1 : ((c / 5) % 2);
`else
            owner = (c == 20) ? -1 : 0;
`endif
            if (owner >= 0) cur_sel = owner;
            sb.push_back(expect_beat(owner, cur_sel, out_ready));
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL timeout c%0d: got g=%b s=%0d v=%b d=%h x=%b want g=%b s=%0d v=%b d=%h x=%b",
                         c, o.g, o.s, o.v, o.d, o.x, e.g, e.s, e.v, e.d, e.x);
            end
        end
    endtask

    // A lone requester is never forced off, even with the hold counter saturated.
    task automatic test_lone_hold();
        obs_t e, o;
        int   owner;
        out_ready = 1'b0;
        for (int c = 0; c < 9; c++) begin
            req   = (c < 8) ? 4'b0001 : 4'b0000;
            owner = (c < 8) ? 0 : -1;
            if (owner >= 0) cur_sel = owner;
            sb.push_back(expect_beat(owner, cur_sel, out_ready));
            @(posedge clk); #1;
            e = sb.pop_front(); o = observe(); checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL lone_hold c%0d: got g=%b s=%0d v=%b d=%h x=%b want g=%b s=%0d v=%b d=%h x=%b",
                         c, o.g, o.s, o.v, o.d, o.x, e.g, e.s, e.v, e.d, e.x);
            end
        end
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; in = data_words; out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic_rr();
        test_top_requester();
        test_back_to_back();
        test_stall();
        test_reset_mid_grant();
        test_timeout();
        test_lone_hold();
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
